// File: rtl/sauria_pkg.sv
// Shared definitions for the SAURIA configuration-plane blocks: command op
// encoding and AXI response helpers.
package sauria_pkg;

  // Op code 3 is reserved; consumers treat it as a plain read.
  typedef enum logic [1:0] {
    CFG_WR   = 2'd0,
    CFG_RD   = 2'd1,
    CFG_POLL = 2'd2
  } cfg_op_e;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  function automatic logic axi_resp_is_err(input logic [1:0] resp);
    return resp != AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/sauria_cfg_lite_master.sv
// Single-outstanding AXI4-Lite master turning write / read / poll commands
// into register accesses, with one response per command.
module sauria_cfg_lite_master
  import sauria_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TMO_W  = 16
) (
  input  logic                i_system_clk,
  input  logic                i_system_rst,

  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic [1:0]          i_cmd_op,
  input  logic [ADDR_W-1:0]   i_cmd_addr,
  input  logic [DATA_W-1:0]   i_cmd_data,
  input  logic [DATA_W-1:0]   i_cmd_mask,
  input  logic [TMO_W-1:0]    i_cmd_tmo,

  output logic                o_rsp_valid,
  input  logic                i_rsp_ready,
  output logic [DATA_W-1:0]   o_rsp_data,
  output logic                o_rsp_err,
  output logic                o_rsp_tmo,
  output logic                o_busy,

  output logic [ADDR_W-1:0]   o_cfg_axi_awaddr,
  output logic                o_cfg_axi_awvalid,
  input  logic                i_cfg_axi_awready,

  output logic [DATA_W-1:0]   o_cfg_axi_wdata,
  output logic [DATA_W/8-1:0] o_cfg_axi_wstrb,
  output logic                o_cfg_axi_wvalid,
  input  logic                i_cfg_axi_wready,

  input  logic [1:0]          i_cfg_axi_bresp,
  input  logic                i_cfg_axi_bvalid,
  output logic                o_cfg_axi_bready,

  output logic [ADDR_W-1:0]   o_cfg_axi_araddr,
  output logic                o_cfg_axi_arvalid,
  input  logic                i_cfg_axi_arready,

  input  logic [DATA_W-1:0]   i_cfg_axi_rdata,
  input  logic [1:0]          i_cfg_axi_rresp,
  input  logic                i_cfg_axi_rvalid,
  output logic                o_cfg_axi_rready
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WAIT_B,
    RD_A,
    RD_R,
    RSP
  } state_e;

  state_e state, state_nxt;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] mask_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic [TMO_W-1:0]  cnt_q;
  logic              is_poll_q;
  logic              aw_done_q;
  logic              w_done_q;
  logic              rsp_err_q;
  logic              rsp_tmo_q;

  logic cmd_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic r_err, poll_match, poll_retry;

  assign cmd_hs = i_cmd_valid       && o_cmd_ready;
  assign aw_hs  = o_cfg_axi_awvalid && i_cfg_axi_awready;
  assign w_hs   = o_cfg_axi_wvalid  && i_cfg_axi_wready;
  assign b_hs   = i_cfg_axi_bvalid  && o_cfg_axi_bready;
  assign ar_hs  = o_cfg_axi_arvalid && i_cfg_axi_arready;
  assign r_hs   = i_cfg_axi_rvalid  && o_cfg_axi_rready;

  assign r_err      = axi_resp_is_err(i_cfg_axi_rresp);
  assign poll_match = ((i_cfg_axi_rdata ^ data_q) & mask_q) == '0;
  // A failing poll read loops back only while retries remain; bus errors never retry.
  assign poll_retry = is_poll_q && !r_err && !poll_match && (cnt_q != '0);

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge i_system_clk) begin
    if (i_system_rst) state <= IDLE;
    else              state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (cmd_hs) state_nxt = (i_cmd_op == CFG_WR) ? WR : RD_A;
      WR:      if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_nxt = WAIT_B;
      WAIT_B:  if (b_hs) state_nxt = RSP;
      RD_A:    if (ar_hs) state_nxt = RD_R;
      RD_R:    if (r_hs) state_nxt = poll_retry ? RD_A : RSP;
      RSP:     if (i_rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake flags are registered, so VALIDs never see READY combinationally.
  always_comb begin
    o_cmd_ready       = 1'b0;
    o_busy            = 1'b1;
    o_cfg_axi_awvalid = 1'b0;
    o_cfg_axi_wvalid  = 1'b0;
    o_cfg_axi_bready  = 1'b0;
    o_cfg_axi_arvalid = 1'b0;
    o_cfg_axi_rready  = 1'b0;
    o_rsp_valid       = 1'b0;
    unique case (state)
      IDLE: begin
        o_cmd_ready = 1'b1;
        o_busy      = 1'b0;
      end
      WR: begin
        o_cfg_axi_awvalid = !aw_done_q;
        o_cfg_axi_wvalid  = !w_done_q;
      end
      WAIT_B:  o_cfg_axi_bready  = 1'b1;
      RD_A:    o_cfg_axi_arvalid = 1'b1;
      RD_R:    o_cfg_axi_rready  = 1'b1;
      RSP:     o_rsp_valid       = 1'b1;
      default: o_busy            = 1'b0;
    endcase
  end

  always_ff @(posedge i_system_clk) begin
    if (i_system_rst) begin
      addr_q     <= '0;
      data_q     <= '0;
      mask_q     <= '0;
      cnt_q      <= '0;
      is_poll_q  <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      rsp_tmo_q  <= 1'b0;
    end else begin
      if (cmd_hs) begin
        addr_q     <= i_cmd_addr;
        data_q     <= i_cmd_data;
        mask_q     <= i_cmd_mask;
        cnt_q      <= i_cmd_tmo;
        is_poll_q  <= (i_cmd_op == CFG_POLL);
        aw_done_q  <= 1'b0;
        w_done_q   <= 1'b0;
        rsp_data_q <= '0;
        rsp_err_q  <= 1'b0;
        rsp_tmo_q  <= 1'b0;
      end
      if (aw_hs) aw_done_q <= 1'b1;
      if (w_hs)  w_done_q  <= 1'b1;
      if (b_hs)  rsp_err_q <= axi_resp_is_err(i_cfg_axi_bresp);
      if (r_hs) begin
        rsp_data_q <= i_cfg_axi_rdata;
        rsp_err_q  <= r_err;
        if (is_poll_q && !r_err && !poll_match) begin
          if (cnt_q == '0) rsp_tmo_q <= 1'b1;
          else             cnt_q     <= cnt_q - TMO_W'(1);
        end
      end
    end
  end

  assign o_cfg_axi_awaddr = addr_q;
  assign o_cfg_axi_araddr = addr_q;
  assign o_cfg_axi_wdata  = data_q;
  assign o_cfg_axi_wstrb  = '1;

  assign o_rsp_data = rsp_data_q;
  assign o_rsp_err  = rsp_err_q;
  assign o_rsp_tmo  = rsp_tmo_q;

endmodule

// File: tb/tb_sauria_cfg_lite_master.sv
// Bench for sauria_cfg_lite_master: directed and randomized commands against a
// configurable AXI4-Lite slave, checked with a command-level response model.
`timescale 1ns/1ps
module tb_sauria_cfg_lite_master;
  import sauria_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [31:0] cmd_addr = '0, cmd_data = '0, cmd_mask = '0;
  logic [15:0] cmd_tmo = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err, rsp_tmo, busy;
  logic [31:0] rsp_data;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  wstrb;
  logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
  logic [1:0]  bresp = '0;
  logic        bvalid = 1'b0, bready;
  logic        arvalid, arready = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rvalid = 1'b0, rready;

  always #5 clk = ~clk;

  sauria_cfg_lite_master #(.ADDR_W(32), .DATA_W(32), .TMO_W(16)) dut (
    .i_system_clk(clk), .i_system_rst(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_op(cmd_op),
    .i_cmd_addr(cmd_addr), .i_cmd_data(cmd_data), .i_cmd_mask(cmd_mask), .i_cmd_tmo(cmd_tmo),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data),
    .o_rsp_err(rsp_err), .o_rsp_tmo(rsp_tmo), .o_busy(busy),
    .o_cfg_axi_awaddr(awaddr), .o_cfg_axi_awvalid(awvalid), .i_cfg_axi_awready(awready),
    .o_cfg_axi_wdata(wdata), .o_cfg_axi_wstrb(wstrb), .o_cfg_axi_wvalid(wvalid),
    .i_cfg_axi_wready(wready),
    .i_cfg_axi_bresp(bresp), .i_cfg_axi_bvalid(bvalid), .o_cfg_axi_bready(bready),
    .o_cfg_axi_araddr(araddr), .o_cfg_axi_arvalid(arvalid), .i_cfg_axi_arready(arready),
    .i_cfg_axi_rdata(rdata), .i_cfg_axi_rresp(rresp), .i_cfg_axi_rvalid(rvalid),
    .o_cfg_axi_rready(rready)
  );

  int errors = 0;
  int checks = 0;

  // Slave configuration for the next command
  int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  logic [1:0]  bresp_cfg = 2'b00;
  logic [31:0] rd_data_q[$];
  logic [1:0]  rd_resp_q[$];

  // Monitor results, cleared per command
  int          aw_count = 0, w_count = 0, b_count = 0, ar_count = 0, r_count = 0;
  int          aw_hi = 0, w_hi = 0, proto_err = 0;
  logic [31:0] last_awaddr = '0, last_wdata = '0, last_araddr = '0;

  // Slave + monitor. Runs just after the falling edge: DUT outputs are settled and
  // the readies chosen here are what the next rising edge sees, so handshakes are
  // booked here as happening at that edge.
  initial begin
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    logic aw_seen, w_seen, b_pending, r_pending, aw_stall, w_stall, ar_stall;
    logic [31:0] st_awaddr, st_wdata, st_araddr;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    aw_seen = 0; w_seen = 0; b_pending = 0; r_pending = 0;
    aw_stall = 0; w_stall = 0; ar_stall = 0;
    st_awaddr = '0; st_wdata = '0; st_araddr = '0;
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; bresp = 0; rresp = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        aw_seen = 0; w_seen = 0; b_pending = 0; r_pending = 0;
        aw_stall = 0; w_stall = 0; ar_stall = 0;
      end else begin
        if (aw_stall && (awvalid !== 1'b1 || awaddr !== st_awaddr)) proto_err++;
        if (w_stall  && (wvalid  !== 1'b1 || wdata  !== st_wdata))  proto_err++;
        if (ar_stall && (arvalid !== 1'b1 || araddr !== st_araddr)) proto_err++;
        awready = 0;
        if (awvalid) begin if (aw_cnt >= aw_delay) awready = 1; else aw_cnt++; end
        wready = 0;
        if (wvalid) begin if (w_cnt >= w_delay) wready = 1; else w_cnt++; end
        arready = 0;
        if (arvalid) begin if (ar_cnt >= ar_delay) arready = 1; else ar_cnt++; end
        bvalid = 0; bresp = 0;
        if (b_pending) begin
          if (b_cnt >= b_delay) begin bvalid = 1; bresp = bresp_cfg; end else b_cnt++;
        end
        rvalid = 0; rdata = '0; rresp = 0;
        if (r_pending) begin
          if (r_cnt >= r_delay) begin
            rvalid = 1;
            rdata = (rd_data_q.size() > 0) ? rd_data_q[0] : '0;
            rresp = (rd_resp_q.size() > 0) ? rd_resp_q[0] : 2'b00;
          end else r_cnt++;
        end
        if (awvalid) aw_hi++;
        if (wvalid)  w_hi++;
        if (awvalid && awready) begin
          aw_count++; last_awaddr = awaddr; aw_seen = 1; aw_cnt = 0;
        end
        if (wvalid && wready) begin
          w_count++; last_wdata = wdata; w_seen = 1; w_cnt = 0;
          if (wstrb !== 4'hF) proto_err++;
        end
        if (aw_seen && w_seen) begin aw_seen = 0; w_seen = 0; b_pending = 1; b_cnt = 0; end
        if (bvalid && bready) begin b_count++; b_pending = 0; end
        if (arvalid && arready) begin
          ar_count++; last_araddr = araddr; r_pending = 1; r_cnt = 0; ar_cnt = 0;
        end
        if (rvalid && rready) begin
          r_count++; r_pending = 0;
          if (rd_data_q.size() > 0) void'(rd_data_q.pop_front());
          if (rd_resp_q.size() > 0) void'(rd_resp_q.pop_front());
        end
        aw_stall = awvalid && !awready; st_awaddr = awaddr;
        w_stall  = wvalid  && !wready;  st_wdata  = wdata;
        ar_stall = arvalid && !arready; st_araddr = araddr;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk); rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic set_slave(input int awd, wd, bd, ard, rd);
    aw_delay = awd; w_delay = wd; b_delay = bd; ar_delay = ard; r_delay = rd;
  endtask

  // Issue one command, model its outcome from the queued slave behaviour and
  // check the response, bus traffic and return to idle. exp_lat < 0 skips latency.
  task automatic run_cmd(input string name, input logic [1:0] op, input logic [31:0] addr,
                         input logic [31:0] data, input logic [31:0] mask,
                         input logic [15:0] tmo, input int hold, input int exp_lat);
    int exp_reads, exp_writes, cyc;
    logic [31:0] exp_data, d;
    logic [1:0] r;
    logic exp_err, exp_tmo;
    exp_reads = 0; exp_writes = 0; exp_data = '0; exp_err = 0; exp_tmo = 0;
    if (op == 2'd0) begin
      exp_writes = 1;
      exp_err = (bresp_cfg != 2'b00);
    end else if (op == 2'd2) begin
      for (int i = 0; i <= int'(tmo); i++) begin
        d = (i < rd_data_q.size()) ? rd_data_q[i] : '0;
        r = (i < rd_resp_q.size()) ? rd_resp_q[i] : 2'b00;
        exp_reads = i + 1;
        exp_data = d;
        if (r != 2'b00) begin exp_err = 1; break; end
        if ((d & mask) == (data & mask)) break;
        if (i == int'(tmo)) exp_tmo = 1;
      end
    end else begin
      exp_reads = 1;
      exp_data = (rd_data_q.size() > 0) ? rd_data_q[0] : '0;
      exp_err = (rd_resp_q.size() > 0) && (rd_resp_q[0] != 2'b00);
    end

    @(negedge clk);
    aw_count = 0; w_count = 0; b_count = 0; ar_count = 0; r_count = 0; aw_hi = 0; w_hi = 0;
    cmd_valid = 1; cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_mask = mask; cmd_tmo = tmo;
    cyc = 0;
    while (cmd_ready !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
    if (cmd_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL %s accept: cmd_ready=%b after %0d cycles, expected 1", name, cmd_ready, cyc);
      cmd_valid = 0; do_reset(); return;
    end
    @(negedge clk);
    cmd_valid = 0; cmd_op = 2'($urandom); cmd_addr = $urandom; cmd_data = $urandom;
    cmd_mask = $urandom; cmd_tmo = 16'($urandom);
    cyc = 1;
    while (rsp_valid !== 1'b1 && cyc < 500) begin @(negedge clk); cyc++; end
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s rsp_timeout: no rsp_valid after %0d cycles", name, cyc);
      do_reset(); return;
    end
    if (exp_lat >= 0) begin
      checks++;
      if (cyc !== exp_lat) begin
        errors++; $display("FAIL %s latency: got %0d cycles, expected %0d", name, cyc, exp_lat);
      end
    end
    checks++;
    if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
      errors++; $display("FAIL %s rsp_state: busy=%b cmd_ready=%b, expected 1/0", name, busy, cmd_ready);
    end
    rsp_ready = (hold == 0);
    for (int i = 0; i <= hold; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp_data || rsp_err !== exp_err || rsp_tmo !== exp_tmo) begin
        errors++;
        $display("FAIL %s rsp[hold %0d]: valid=%b data=%h err=%b tmo=%b, expected 1 %h %b %b",
                 name, i, rsp_valid, rsp_data, rsp_err, rsp_tmo, exp_data, exp_err, exp_tmo);
      end
      if (i < hold) @(negedge clk);
      if (i == hold - 1) rsp_ready = 1;
    end
    @(negedge clk);
    rsp_ready = 0;
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: cmd_ready=%b busy=%b rsp_valid=%b, expected 1 0 0",
               name, cmd_ready, busy, rsp_valid);
    end
    checks++;
    if (aw_count !== exp_writes || w_count !== exp_writes || b_count !== exp_writes ||
        ar_count !== exp_reads || r_count !== exp_reads) begin
      errors++;
      $display("FAIL %s beats: aw=%0d w=%0d b=%0d ar=%0d r=%0d, expected %0d %0d %0d %0d %0d", name,
               aw_count, w_count, b_count, ar_count, r_count,
               exp_writes, exp_writes, exp_writes, exp_reads, exp_reads);
    end
    if (exp_writes > 0) begin
      checks++;
      if (last_awaddr !== addr || last_wdata !== data) begin
        errors++;
        $display("FAIL %s wr_payload: awaddr=%h wdata=%h, expected %h %h", name,
                 last_awaddr, last_wdata, addr, data);
      end
    end else begin
      checks++;
      if (last_araddr !== addr) begin
        errors++; $display("FAIL %s araddr: got %h, expected %h", name, last_araddr, addr);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    checks++;
    if ({awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_err, rsp_tmo, busy} !== 9'b0 ||
        rsp_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: aw=%b w=%b b=%b ar=%b r=%b rv=%b err=%b tmo=%b busy=%b data=%h, expected all 0",
               awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_err, rsp_tmo, busy, rsp_data);
    end
    rst = 0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle: cmd_ready=%b busy=%b, expected 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_write_basic();
    set_slave(0, 0, 0, 0, 0); bresp_cfg = 2'b00;
    run_cmd("write_basic", CFG_WR, 32'h10, 32'hDEADBEEF, 32'h0, 16'd0, 0, 3);
  endtask

  task automatic test_write_aw_delay();
    set_slave(4, 0, 0, 0, 0); bresp_cfg = 2'b00;
    run_cmd("write_aw_delay", CFG_WR, 32'h20, 32'hCAFE0001, 32'h0, 16'd0, 1, -1);
    checks++;
    if (aw_hi !== 5 || w_hi !== 1) begin
      errors++; $display("FAIL write_aw_delay valid_cycles: aw=%0d w=%0d, expected 5 1", aw_hi, w_hi);
    end
    set_slave(0, 3, 1, 0, 0); bresp_cfg = 2'b10;
    run_cmd("write_w_delay_slverr", CFG_WR, 32'h24, 32'h0BAD0BAD, 32'h0, 16'd0, 0, -1);
  endtask

  task automatic test_read();
    set_slave(0, 0, 0, 0, 0);
    rd_data_q = '{32'h12345678}; rd_resp_q = '{2'b10};
    run_cmd("read_slverr", CFG_RD, 32'h4, 32'h0, 32'h0, 16'd0, 0, 3);
    set_slave(0, 0, 0, 2, 3);
    rd_data_q = '{32'hA5A55A5A}; rd_resp_q = '{2'b00};
    run_cmd("read_reserved_op", 2'd3, 32'h40, 32'h0, 32'h0, 16'd0, 2, -1);
  endtask

  task automatic test_poll();
    set_slave(0, 0, 0, 0, 0);
    rd_data_q = '{32'h0, 32'h0, 32'h1}; rd_resp_q = '{2'b00, 2'b00, 2'b00};
    run_cmd("poll_match", CFG_POLL, 32'h8, 32'h1, 32'h1, 16'd3, 0, -1);
    rd_data_q = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0}; rd_resp_q = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    run_cmd("poll_timeout", CFG_POLL, 32'h8, 32'h1, 32'h1, 16'd2, 5, -1);
    rd_data_q = '{32'h0, 32'hABCD0000, 32'h1}; rd_resp_q = '{2'b00, 2'b11, 2'b00};
    run_cmd("poll_err_abort", CFG_POLL, 32'hC, 32'h1, 32'h1, 16'd5, 1, -1);
    rd_data_q = '{32'h0}; rd_resp_q = '{2'b00};
    run_cmd("poll_tmo0", CFG_POLL, 32'hC, 32'h80, 32'h80, 16'd0, 0, -1);
    rd_data_q.delete(); rd_resp_q.delete();
  endtask

  task automatic test_random();
    logic [1:0] op;
    logic [31:0] data, mask, d;
    for (int n = 0; n < 16; n++) begin
      op = 2'($urandom_range(0, 3));
      data = $urandom;
      mask = ($urandom_range(0, 1) == 1) ? $urandom : 32'h000000FF;
      set_slave($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3));
      bresp_cfg = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
      rd_data_q.delete(); rd_resp_q.delete();
      for (int k = 0; k < 7; k++) begin
        d = ($urandom_range(0, 2) == 0) ? ((data & mask) | ($urandom & ~mask)) : $urandom;
        rd_data_q.push_back(d);
        rd_resp_q.push_back(($urandom_range(0, 7) == 0) ? 2'b11 : 2'b00);
      end
      run_cmd("random", op, $urandom & 32'hFFFF_FFFC, data, mask,
              16'($urandom_range(0, 4)), $urandom_range(0, 3), -1);
    end
    rd_data_q.delete(); rd_resp_q.delete();
  endtask

  task automatic test_reset_mid();
    int cyc;
    set_slave(0, 0, 0, 10, 0);
    @(negedge clk);
    cmd_valid = 1; cmd_op = CFG_RD; cmd_addr = 32'h100;
    @(negedge clk);
    cmd_valid = 0;
    cyc = 0;
    while (arvalid !== 1'b1 && cyc < 10) begin @(negedge clk); cyc++; end
    checks++;
    if (arvalid !== 1'b1) begin
      errors++; $display("FAIL reset_mid arvalid: got %b, expected 1", arvalid);
    end
    rst = 1;
    @(negedge clk);
    checks++;
    if ({awvalid, wvalid, bready, arvalid, rready, rsp_valid, busy} !== 7'b0) begin
      errors++;
      $display("FAIL reset_mid outputs: aw=%b w=%b b=%b ar=%b r=%b rv=%b busy=%b, expected all 0",
               awvalid, wvalid, bready, arvalid, rready, rsp_valid, busy);
    end
    rst = 0;
    set_slave(0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_mid cmd_ready: got %b, expected 1", cmd_ready);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b0 || arvalid !== 1'b0) begin
        errors++; $display("FAIL reset_mid quiet[%0d]: rsp_valid=%b arvalid=%b, expected 0 0", i, rsp_valid, arvalid);
      end
      @(negedge clk);
    end
    rd_data_q = '{32'h600DF00D}; rd_resp_q = '{2'b00};
    run_cmd("read_after_reset", CFG_RD, 32'h104, 32'h0, 32'h0, 16'd0, 0, 3);
  endtask

  task automatic test_protocol();
    checks++;
    if (proto_err !== 0) begin
      errors++; $display("FAIL protocol: %0d VALID/payload stability or WSTRB violations, expected 0", proto_err);
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_write_aw_delay();
    test_read();
    test_poll();
    test_random();
    test_reset_mid();
    test_protocol();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
